// File: rtl/s_memory_checker.sv
// s_memory_checker
//
// Read-back engine for the 256x8 S memory. A start request in IDLE sweeps
// addresses 0x00..0xFF through the memory read port. Each returned byte is
// compared against its own address, which is the identity pattern s[i] = i.
// A 16-bit byte checksum is accumulated at the same time. The pass/fail
// verdict is held after the run for the controller and the LEDs/HEX.
//
// Parameters
//   READ_LATENCY  cycles from address driven to matching q valid (1 or 2)
//
// Ports
//   clock           system clock, rising edge
//   reset_n         asynchronous active-low reset
//   start           run request, sampled only in IDLE
//   busy            high in READ and DRAIN
//   done            one-cycle pulse when the results are final
//   address         S-memory address; holds 0xFF after a sweep
//   data            S-memory write data, tied to 0
//   wren            S-memory write enable, tied to 0
//   q               S-memory read data
//   pass            all 256 bytes matched their address
//   mismatch_count  number of failing locations (0..256)
//   first_bad_addr  lowest failing address, 0 when none failed
//   checksum        unsigned sum of all 256 bytes read
//   state_dbg       current FSM state (IDLE=0, READ=1, DRAIN=2, DONE=3)
//
// Handshake: start is a level, not a valid/ready pair. It is acted on only in
// an IDLE cycle and is otherwise dropped without being queued. done is a
// single-cycle strobe; the results stay stable from the done cycle until the
// next accepted start.

module s_memory_checker #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [7:0]  address,
    output logic [7:0]  data,
    output logic        wren,
    input  logic [7:0]  q,
    output logic        pass,
    output logic [8:0]  mismatch_count,
    output logic [7:0]  first_bad_addr,
    output logic [15:0] checksum,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [1:0] LAT_M1 = 2'(READ_LATENCY - 1);

    state_e      state_q, state_d;
    logic [1:0]  drain_q, drain_d;
    logic [7:0]  addr_q, addr_d;
    logic [8:0]  mcnt_q, mcnt_d;
    logic [7:0]  fbad_q, fbad_d;
    logic        seen_q, seen_d;
    logic [15:0] csum_q, csum_d;
    logic        pass_q, pass_d;

    // Expected-value pipeline. It is as deep as the memory read latency, so
    // its last stage lines up with the q that belongs to it.
    logic [7:0]              exp_q [READ_LATENCY];
    logic [READ_LATENCY-1:0] vld_q;

    logic       start_run;
    logic       smp_vld;
    logic [7:0] smp_exp;
    logic       smp_bad;

    assign start_run = (state_q == S_IDLE) && start;
    assign smp_vld   = vld_q[READ_LATENCY-1];
    assign smp_exp   = exp_q[READ_LATENCY-1];
    assign smp_bad   = smp_vld && (q != smp_exp);

    // ---------------- FSM ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            drain_q <= 2'd0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_READ;
            end
            S_READ: begin
                // Stop on the last address itself, never on a counter wrap.
                if (addr_q == 8'hFF) begin
                    state_d = S_DRAIN;
                    drain_d = 2'd0;
                end
            end
            S_DRAIN: begin
                if (drain_q == LAT_M1) state_d = S_DONE;
                else                   drain_d = drain_q + 2'd1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------- datapath ----------------
    always_comb begin
        addr_d = addr_q;
        mcnt_d = mcnt_q;
        fbad_d = fbad_q;
        seen_d = seen_q;
        csum_d = csum_q;
        pass_d = pass_q;
        if (start_run) begin
            addr_d = 8'h00;
            mcnt_d = 9'd0;
            fbad_d = 8'h00;
            seen_d = 1'b0;
            csum_d = 16'h0000;
            pass_d = 1'b0;
        end else begin
            if ((state_q == S_READ) && (addr_q != 8'hFF)) addr_d = addr_q + 8'd1;
            if (smp_vld) begin
                csum_d = csum_q + {8'h00, q};
                if (smp_bad) begin
                    mcnt_d = mcnt_q + 9'd1;
                    if (!seen_q) begin
                        fbad_d = smp_exp;
                        seen_d = 1'b1;
                    end
                end
            end
            // The last sample lands on the same edge that enters DONE, so
            // the verdict uses the updated count rather than the register.
            if ((state_q == S_DRAIN) && (state_d == S_DONE)) pass_d = (mcnt_d == 9'd0);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= 8'h00;
            mcnt_q <= 9'd0;
            fbad_q <= 8'h00;
            seen_q <= 1'b0;
            csum_q <= 16'h0000;
            pass_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            mcnt_q <= mcnt_d;
            fbad_q <= fbad_d;
            seen_q <= seen_d;
            csum_q <= csum_d;
            pass_q <= pass_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) exp_q[i] <= 8'h00;
        end else begin
            vld_q[0] <= (state_q == S_READ);
            exp_q[0] <= addr_q;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                exp_q[i] <= exp_q[i-1];
            end
        end
    end

    // ---------------- outputs ----------------
    assign busy           = (state_q == S_READ) || (state_q == S_DRAIN);
    assign done           = (state_q == S_DONE);
    assign address        = addr_q;
    assign data           = 8'h00;
    assign wren           = 1'b0;
    assign pass           = pass_q;
    assign mismatch_count = mcnt_q;
    assign first_bad_addr = fbad_q;
    assign checksum       = csum_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_s_memory_checker.sv
module tb_s_memory_checker;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs: latency 1 and latency 2 ----------------
    logic [7:0] mem [256];
    int         sel = 1;
    logic       start_drv = 1'b0;

    logic        start1, busy1, done1, wren1, pass1;
    logic [7:0]  addr1, data1, q1, fb1;
    logic [8:0]  mc1;
    logic [15:0] cs1;
    logic [1:0]  st1;
    logic        start2, busy2, done2, wren2, pass2;
    logic [7:0]  addr2, data2, q2, q2a, fb2;
    logic [8:0]  mc2;
    logic [15:0] cs2;
    logic [1:0]  st2;

    assign start1 = start_drv && (sel == 1);
    assign start2 = start_drv && (sel == 2);

    s_memory_checker #(.READ_LATENCY(1)) u_lat1 (
        .clock(clk), .reset_n(reset_n), .start(start1), .busy(busy1), .done(done1),
        .address(addr1), .data(data1), .wren(wren1), .q(q1), .pass(pass1),
        .mismatch_count(mc1), .first_bad_addr(fb1), .checksum(cs1), .state_dbg(st1)
    );

    s_memory_checker #(.READ_LATENCY(2)) u_lat2 (
        .clock(clk), .reset_n(reset_n), .start(start2), .busy(busy2), .done(done2),
        .address(addr2), .data(data2), .wren(wren2), .q(q2), .pass(pass2),
        .mismatch_count(mc2), .first_bad_addr(fb2), .checksum(cs2), .state_dbg(st2)
    );

    // Synchronous memories: one register stage for latency 1, two for latency 2.
    always @(posedge clk) begin
        q1  <= mem[addr1];
        q2a <= mem[addr2];
        q2  <= q2a;
    end

    // Outputs of the DUT currently under test.
    logic        m_busy, m_done, m_wren, m_pass;
    logic [7:0]  m_addr, m_data, m_fb;
    logic [8:0]  m_mc;
    logic [15:0] m_cs;
    assign m_busy = (sel == 2) ? busy2 : busy1;
    assign m_done = (sel == 2) ? done2 : done1;
    assign m_wren = (sel == 2) ? wren2 : wren1;
    assign m_pass = (sel == 2) ? pass2 : pass1;
    assign m_addr = (sel == 2) ? addr2 : addr1;
    assign m_data = (sel == 2) ? data2 : data1;
    assign m_fb   = (sel == 2) ? fb2   : fb1;
    assign m_mc   = (sel == 2) ? mc2   : mc1;
    assign m_cs   = (sel == 2) ? cs2   : cs1;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference model: the checker's verdict follows directly from the memory
    // contents, so it is computed here from the array in one pass.
    function automatic void ref_model(output bit p, output int mc, output int fb, output int cs);
        int first = -1;
        mc = 0;
        cs = 0;
        for (int i = 0; i < 256; i++) begin
            cs += int'(mem[i]);
            if (int'(mem[i]) != i) begin
                mc++;
                if (first < 0) first = i;
            end
        end
        p  = (mc == 0);
        fb = (first < 0) ? 0 : first;
    endfunction

    task automatic fill_mem(input int kind);
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        case (kind)
            1: mem[8'h5A] = 8'hA5;
            2: for (int i = 0; i < 256; i++) mem[i] = 8'h00;
            3: for (int i = 0; i < 256; i++)
                   if ($urandom_range(0, 15) == 0) mem[i] = 8'($urandom_range(0, 255));
            4: for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
            5: mem[8'hFF] = 8'h00;
            6: mem[8'h00] = 8'h01;
            default: ;
        endcase
    endtask

    // ---------------- driver tasks ----------------
    // Leaves the bench at the falling edge of the first READ cycle.
    task automatic kick();
        @(negedge clk);
        start_drv = 1'b1;
        @(negedge clk);
        start_drv = 1'b0;
    endtask

    // Follows one run from its first READ cycle, checking the address sweep,
    // busy/done timing, the tied write bus and the final results.
    task automatic watch_run(input string tag, input bit exp_pass, input int exp_mc,
                             input int exp_fb, input int exp_cs,
                             input bit mid_start, input bit hold_end);
        int lat = sel;
        int done_at = -1;
        int done_cnt = 0;
        int seq_err = 0;
        int bus_err = 0;
        for (int c = 0; c < 700; c++) begin
            if (m_wren !== 1'b0 || m_data !== 8'h00) bus_err++;
            if (m_done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = c;
                    check({tag, ".busy_at_done"}, int'(m_busy), 0);
                    check({tag, ".pass"}, int'(m_pass), int'(exp_pass));
                    check({tag, ".mismatch_count"}, int'(m_mc), exp_mc);
                    check({tag, ".first_bad_addr"}, int'(m_fb), exp_fb);
                    check({tag, ".checksum"}, int'(m_cs), exp_cs);
                end
            end else if (done_at < 0) begin
                if (m_busy !== 1'b1) seq_err++;
                if (c < 256) begin
                    if (m_addr !== 8'(c)) seq_err++;
                end else if (m_addr !== 8'hFF) seq_err++;
            end
            if (mid_start && c == 64) start_drv = 1'b1;
            if (mid_start && c == 65) start_drv = 1'b0;
            if (hold_end && c == 250) start_drv = 1'b1;
            if (done_at >= 0 && c == done_at + 1) begin
                check({tag, ".busy_after"}, int'(m_busy), 0);
                check({tag, ".addr_hold"}, int'(m_addr), 'hFF);
                check({tag, ".hold_pass"}, int'(m_pass), int'(exp_pass));
                check({tag, ".hold_checksum"}, int'(m_cs), exp_cs);
                if (!hold_end) break;
            end
            if (hold_end && done_at >= 0 && c == done_at + 2) begin
                check({tag, ".rerun_busy"}, int'(m_busy), 1);
                check({tag, ".rerun_addr"}, int'(m_addr), 0);
                check({tag, ".rerun_mc_clr"}, int'(m_mc), 0);
                check({tag, ".rerun_cs_clr"}, int'(m_cs), 0);
                check({tag, ".rerun_pass_clr"}, int'(m_pass), 0);
                start_drv = 1'b0;
                break;
            end
            @(negedge clk);
        end
        check({tag, ".done_latency"}, done_at, 256 + lat);
        check({tag, ".done_pulses"}, done_cnt, 1);
        check({tag, ".addr_busy_seq"}, seq_err, 0);
        check({tag, ".bus_tied"}, bus_err, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int kind;
        int lat;
        bit exp_pass;
        int exp_mc;
        int exp_fb;
        int exp_cs;
    } vec_t;

    vec_t vecs [10];

    initial begin
        bit p;
        int mc, fb, cs, guard, dcnt;

        vecs[0] = '{0, 1, 1'b1, 0,   'h00, 'h7F80};
        vecs[1] = '{1, 1, 1'b0, 1,   'h5A, 'h7FCB};
        vecs[2] = '{2, 1, 1'b0, 255, 'h01, 'h0000};
        vecs[3] = '{5, 1, 1'b0, 1,   'hFF, 'h7E81};
        vecs[4] = '{6, 1, 1'b0, 1,   'h00, 'h7F81};
        vecs[5] = '{0, 2, 1'b1, 0,   'h00, 'h7F80};
        vecs[6] = '{1, 2, 1'b0, 1,   'h5A, 'h7FCB};
        vecs[7] = '{2, 2, 1'b0, 255, 'h01, 'h0000};
        vecs[8] = '{5, 2, 1'b0, 1,   'hFF, 'h7E81};
        vecs[9] = '{6, 2, 1'b0, 1,   'h00, 'h7F81};

        fill_mem(0);
        repeat (3) @(negedge clk);
        // Reset values, both instances.
        check("reset.busy1", int'(busy1), 0);
        check("reset.done1", int'(done1), 0);
        check("reset.addr1", int'(addr1), 0);
        check("reset.cs1", int'(cs1), 0);
        check("reset.pass2", int'(pass2), 0);
        check("reset.mc2", int'(mc2), 0);
        reset_n = 1'b1;

        // Table-driven runs.
        for (int v = 0; v < 10; v++) begin
            sel = vecs[v].lat;
            fill_mem(vecs[v].kind);
            kick();
            watch_run($sformatf("vec%0d", v), vecs[v].exp_pass, vecs[v].exp_mc,
                      vecs[v].exp_fb, vecs[v].exp_cs, 1'b0, 1'b0);
        end

        // Randomized contents checked against the reference model.
        for (int r = 0; r < 6; r++) begin
            sel = (r % 2) + 1;
            fill_mem((r < 4) ? 3 : 4);
            ref_model(p, mc, fb, cs);
            kick();
            watch_run($sformatf("rnd%0d", r), p, mc, fb, cs, 1'b0, 1'b0);
        end

        // Start pulsed at address 0x40 is ignored; start held through DONE
        // launches a second run with cleared results.
        sel = 1;
        fill_mem(0);
        kick();
        watch_run("midstart", 1'b1, 0, 0, 'h7F80, 1'b1, 1'b1);
        watch_run("rerun", 1'b1, 0, 0, 'h7F80, 1'b0, 1'b0);

        // Asynchronous reset in the middle of READ.
        sel = 1;
        fill_mem(0);
        kick();
        guard = 0;
        while (m_addr !== 8'h64 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("rst.reach_addr64", int'(m_addr), 'h64);
        #2 reset_n = 1'b0;
        #1;
        check("rst.busy", int'(m_busy), 0);
        check("rst.done", int'(m_done), 0);
        check("rst.addr", int'(m_addr), 0);
        check("rst.pass", int'(m_pass), 0);
        check("rst.mc", int'(m_mc), 0);
        check("rst.fb", int'(m_fb), 0);
        check("rst.cs", int'(m_cs), 0);
        dcnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (m_done === 1'b1 || m_busy === 1'b1) dcnt++;
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst.idle_after", int'(m_busy) + int'(m_done), 0);
        check("rst.no_done", dcnt, 0);
        fill_mem(1);
        kick();
        watch_run("after_rst", 1'b0, 1, 'h5A, 'h7FCB, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
